// File: rtl/lcd_spi_byte_tx_pkg.sv
// Shared types and constants for the LCD SPI byte serializer.
// Holds the FSM encoding plus the ST7789-class command bytes the sequencer emits.
package lcd_spi_byte_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } lcd_state_e;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lcd_spi_byte_tx_sck_tick.sv
// SCK phase timer: pulses tick on the last sys clock of every CLK_DIV-cycle half period.
// Restarts from zero whenever a byte is loaded so each byte begins on a full low phase.
module lcd_sck_tick
  import lcd_spi_byte_tx_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = cnt_w(CLK_DIV);

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || clr || !en || tick) cnt_q <= '0;
    else                             cnt_q <= cnt_q + CW'(1);
  end

endmodule

// File: rtl/lcd_spi_byte_tx.sv
// Mode-0 MSB-first SPI byte serializer for the LCD: owns SCK timing, CS framing and D/C alignment.
// A one-entry pending buffer lets the next byte load on the same cycle SCK falls after bit 0.
module lcd_spi_byte_tx
  import lcd_spi_byte_tx_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_dc,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       busy,
  output logic       lcd_clk,
  output logic       lcd_cs,
  output logic       lcd_rs,
  output logic       lcd_data
);

  localparam int GW = cnt_w(CS_GAP + 1);

  lcd_state_e    state_q;
  logic          pend_valid_q;
  logic [7:0]    pend_data_q;
  logic          pend_dc_q;
  logic          pend_last_q;
  logic [7:0]    shift_q;
  logic          last_q;
  logic [2:0]    bit_cnt_q;
  logic [GW-1:0] gap_cnt_q;
  logic          cs_q, sck_q, rs_q, mosi_q, ready_q, busy_q;

  logic accept, shifting, tick, byte_end, gap_end, load_go;

  assign accept   = tx_valid && !pend_valid_q;
  assign shifting = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
  // End of the 8th high phase: SCK is about to fall after bit 0.
  assign byte_end = shifting && tick && sck_q && (bit_cnt_q == 3'd7);
  assign gap_end  = (state_q == ST_GAP) && (gap_cnt_q == GW'(CS_GAP));

  assign load_go = pend_valid_q && ((state_q == ST_IDLE) || (state_q == ST_HOLD) ||
                                    gap_end || (byte_end && !last_q));

  lcd_sck_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (shifting),
    .clr   (load_go),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      pend_dc_q    <= 1'b0;
      pend_last_q  <= 1'b0;
      shift_q      <= '0;
      last_q       <= 1'b0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      cs_q         <= 1'b1;
      sck_q        <= 1'b0;
      rs_q         <= 1'b0;
      mosi_q       <= 1'b0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      // Drain wins over accept; accept is impossible while pend is full anyway.
      if (load_go) begin
        pend_valid_q <= 1'b0;
        ready_q      <= 1'b1;
      end else if (accept) begin
        pend_valid_q <= 1'b1;
        ready_q      <= 1'b0;
        pend_data_q  <= tx_data;
        pend_dc_q    <= tx_dc;
        pend_last_q  <= tx_last;
      end

      if (load_go) begin
        state_q   <= ST_LOAD;
        shift_q   <= pend_data_q;
        last_q    <= pend_last_q;
        rs_q      <= pend_dc_q;
        mosi_q    <= pend_data_q[7];
        cs_q      <= 1'b0;
        sck_q     <= 1'b0;
        bit_cnt_q <= '0;
        busy_q    <= 1'b1;
      end else begin
        busy_q <= 1'b1;
        case (state_q)
          ST_IDLE: busy_q <= accept;
          ST_LOAD, ST_SHIFT: begin
            state_q <= ST_SHIFT;
            if (tick) begin
              if (!sck_q) begin
                sck_q <= 1'b1;
              end else begin
                sck_q <= 1'b0;
                if (bit_cnt_q == 3'd7) begin
                  state_q   <= last_q ? ST_GAP : ST_HOLD;
                  gap_cnt_q <= '0;
                end else begin
                  shift_q   <= {shift_q[6:0], 1'b0};
                  mosi_q    <= shift_q[6];
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                end
              end
            end
          end
          ST_HOLD: state_q <= ST_HOLD;
          ST_GAP: begin
            // First GAP cycle still shows CS low; CS then stays high CS_GAP cycles.
            cs_q <= 1'b1;
            if (gap_cnt_q == GW'(CS_GAP)) begin
              state_q <= ST_IDLE;
              busy_q  <= accept;
            end else begin
              gap_cnt_q <= gap_cnt_q + GW'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign tx_ready = ready_q;
  assign busy     = busy_q;
  assign lcd_clk  = sck_q;
  assign lcd_cs   = cs_q;
  assign lcd_rs   = rs_q;
  assign lcd_data = mosi_q;

endmodule

// File: tb/tb_lcd_spi_byte_tx.sv
// Bench for lcd_spi_byte_tx: directed bytes pushed to a scoreboard, an SPI slave monitor
// sampling on SCK rising edges pops and compares, plus frame-timing and reset checks.
module tb_lcd_spi_byte_tx;
  import lcd_spi_byte_tx_pkg::*;

  localparam int CLK_DIV = 2;
  localparam int CS_GAP  = 4;

  logic       clk = 1'b0;
  logic       reset, tx_valid, tx_dc, tx_last;
  logic [7:0] tx_data;
  logic       tx_ready, busy, lcd_clk, lcd_cs, lcd_rs, lcd_data;

  lcd_spi_byte_tx #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data), .tx_dc(tx_dc),
    .tx_last(tx_last), .tx_ready(tx_ready), .busy(busy), .lcd_clk(lcd_clk),
    .lcd_cs(lcd_cs), .lcd_rs(lcd_rs), .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] d; logic dc; } exp_t;
  exp_t sb_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Monitor state
  int cyc = 0, bitn = 0, edges = 0, lo_len = 0, hi_len = 0, gap_clk_hi = 0;
  int last_low_len = 0, last_edges = 0, last_hi = 0, last_rise = 0;
  int min_per = 0, max_per = 0, bytes_done = 0;
  logic [7:0] sh;
  logic rs0, rs_ok, prev_clk, prev_cs;
  bit in_frame = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic monitor_loop();
    int per;
    exp_t e;
    prev_cs = 1'b1;
    prev_clk = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        bitn = 0; edges = 0; lo_len = 0; in_frame = 0; gap_clk_hi = 0;
        hi_len++;
        prev_cs = 1'b1; prev_clk = 1'b0;
        continue;
      end
      if (lcd_cs) begin
        if (!prev_cs && in_frame) begin
          last_low_len = lo_len; last_edges = edges; in_frame = 0;
          chk("frame_edges_mod8", edges % 8, 0);
        end
        hi_len++;
        if (lcd_clk) gap_clk_hi++;
      end else begin
        if (prev_cs) begin
          chk("cs_gap_min", hi_len >= CS_GAP, 1);
          chk("sck_idle_cs_high", gap_clk_hi, 0);
          last_hi = hi_len; hi_len = 0; gap_clk_hi = 0;
          in_frame = 1; lo_len = 0; edges = 0; min_per = 9999; max_per = 0;
        end
        lo_len++;
        if (lcd_clk && !prev_clk) begin
          if (edges > 0) begin
            per = cyc - last_rise;
            if (per < min_per) min_per = per;
            if (per > max_per) max_per = per;
            if (bitn > 0) chk("sck_period", per, 2 * CLK_DIV);
          end
          last_rise = cyc;
          edges++;
          if (bitn == 0) begin rs0 = lcd_rs; rs_ok = 1'b1; end
          else if (lcd_rs !== rs0) rs_ok = 1'b0;
          sh = {sh[6:0], lcd_data};
          bitn++;
          if (bitn == 8) begin
            bitn = 0;
            bytes_done++;
            if (sb_q.size() == 0) begin
              n_vec++; n_err++;
              $display("FAIL sb_underflow: got byte 0x%0h want none", sh);
            end else begin
              e = sb_q.pop_front();
              chk("byte", sh, e.d);
              chk("dc", rs0, e.dc);
              chk("rs_stable", rs_ok, 1);
            end
          end
        end
      end
      prev_clk = lcd_clk;
      prev_cs  = lcd_cs;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic dc, input logic last);
    int n = 0;
    @(negedge clk);
    tx_valid = 1'b1; tx_data = d; tx_dc = dc; tx_last = last;
    while (!tx_ready && n < 1000) begin @(negedge clk); n++; end
    chk("accept_in_time", n < 1000, 1);
    sb_q.push_back(exp_t'({d, dc}));
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while ((busy || sb_q.size() != 0) && n < 3000);
    chk("idle_in_time", n < 3000, 1);
    chk("sb_drained", sb_q.size(), 0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cs"}, lcd_cs, 1);
    chk({tag, "_clk"}, lcd_clk, 0);
    chk({tag, "_data"}, lcd_data, 0);
    chk({tag, "_ready"}, tx_ready, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int r, n, bad;
    logic pc;
    reset = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_dc = 1'b0; tx_last = 1'b0;
    fork monitor_loop(); join_none
    repeat (4) @(negedge clk);
    chk_reset_state("rst");
    chk("rst_rs", lcd_rs, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single byte with latency probe
    send(8'hA5, 1'b0, 1'b1);
    @(negedge clk); chk("lat_cs_n1", lcd_cs, 1); chk("lat_ready_n1", tx_ready, 0); chk("lat_busy_n1", busy, 1);
    @(negedge clk); chk("lat_cs_n2", lcd_cs, 0); chk("lat_bit7", lcd_data, 1); chk("lat_rs", lcd_rs, 0);
    @(negedge clk); chk("lat_sck_low", lcd_clk, 0);
    @(negedge clk); chk("lat_sck_rise", lcd_clk, 1);
    wait_idle();
    chk("single_cs_low_len", last_low_len, 33);
    chk("single_edges", last_edges, 8);

    // 2: back-to-back within one frame
    send(CMD_CASET, 1'b0, 1'b0);
    send(8'h00, 1'b1, 1'b1);
    wait_idle();
    chk("b2b_edges", last_edges, 16);
    chk("b2b_cs_low_len", last_low_len, 65);
    chk("b2b_min_per", min_per, 4);
    chk("b2b_max_per", max_per, 4);

    // 3: two frames, second pending during the first
    send(CMD_SLPOUT, 1'b0, 1'b1);
    send(CMD_RAMWR, 1'b0, 1'b1);
    wait_idle();
    chk("gap_exact", last_hi, CS_GAP);
    chk("gap_second_edges", last_edges, 8);

    // 4: stream with varying gaps, dc and frame ends
    for (int i = 0; i < 64; i++) begin
      repeat (i % 3) @(negedge clk);
      send(8'((i * 73 + 29) & 255), 1'((i >> 1) & 1), (i % 4) == 3);
    end
    send(8'h5A, 1'b1, 1'b1);
    wait_idle();

    // 5: reset after the 3rd rising SCK edge of 8'hFF
    send(8'hFF, 1'b1, 1'b1);
    r = 0; n = 0; pc = lcd_clk;
    while (r < 3 && n < 200) begin
      @(negedge clk);
      if (lcd_clk && !pc) r++;
      pc = lcd_clk; n++;
    end
    chk("rst_mid_edges_seen", r, 3);
    reset = 1'b1;
    sb_q.delete();
    @(negedge clk);
    chk_reset_state("midrst");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send(8'h3C, 1'b0, 1'b1);
    wait_idle();
    chk("post_rst_edges", last_edges, 8);

    // 6: starvation into HOLD, then completion in the same frame
    n = bytes_done;
    send(8'hC3, 1'b1, 1'b0);
    r = 0;
    while (bytes_done == n && r < 200) begin @(negedge clk); r++; end
    chk("hold_first_byte_done", bytes_done, n + 1);
    repeat (2) @(negedge clk);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (lcd_cs !== 1'b0 || lcd_clk !== 1'b0) bad++;
    end
    chk("hold_cs_low_clk_low", bad, 0);
    chk("hold_busy", busy, 1);
    chk("hold_ready", tx_ready, 1);
    send(8'h55, 1'b0, 1'b1);
    wait_idle();
    chk("hold_frame_edges", last_edges, 16);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
